seq_mag_comparator: RTL and testbench

//  Iterative MSB-first magnitude comparator; parametrised successor of the 8-bit ripple comparator.

---
 rtl/seq_mag_comparator.sv | 104 ++++++++++
 tb/tb_seq_mag_comparator.sv | 132 +++++++++++++
 2 files changed

// File: rtl/seq_mag_comparator.sv
// seq_mag_comparator: iterative MSB-first magnitude comparator.
// Latches A/B on an accepted start and compares DIGIT bits per clock.
// It stops at the first unequal digit, then pulses done with a held 2-bit result.
// Optional macro SIGNED_CMP_EN: two's-complement operands (MSB inverted in digit 0).
module seq_mag_comparator #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [1:0]       Out
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sa, sb, sa_n, sb_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [1:0]       out_n;
  logic             done_n;
  logic [DIGIT-1:0] a_dig, b_dig;

  // Select the current top digit of each shift register for comparison
  always_comb begin
    a_dig = sa[WIDTH-1 -: DIGIT];
    b_dig = sb[WIDTH-1 -: DIGIT];
`ifdef SIGNED_CMP_EN
    // Flipping the sign bits of the most significant digit maps two's complement onto unsigned order
    if (cnt == '0) begin
      a_dig[DIGIT-1] = ~a_dig[DIGIT-1];
      b_dig[DIGIT-1] = ~b_dig[DIGIT-1];
    end
`endif
  end

  // Compute the next state, the shift/count updates and the result to publish
  always_comb begin
    state_n = state;
    sa_n    = sa;
    sb_n    = sb;
    cnt_n   = cnt;
    out_n   = Out;
    done_n  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          sa_n    = A;
          sb_n    = B;
          cnt_n   = '0;
          state_n = RUN;
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        if (a_dig != b_dig) begin
          out_n   = {1'b0, (a_dig > b_dig)};
          done_n  = 1'b1;
          state_n = DONE;
        end else if (cnt == CW'(N - 1)) begin
          out_n   = 2'b10;
          done_n  = 1'b1;
          state_n = DONE;
        end else begin
          sa_n  = sa << DIGIT;
          sb_n  = sb << DIGIT;
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Register the state and datapath; reset overrides any compare in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      cnt   <= '0;
      Out   <= 2'b00;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      sa    <= sa_n;
      sb    <= sb_n;
      cnt   <= cnt_n;
      Out   <= out_n;
      done  <= done_n;
    end
  end

  // busy is decoded from the state register only
  always_comb busy = (state == RUN);

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Directed bench for seq_mag_comparator. Two instances share the same inputs:
// d1 (WIDTH=8, DIGIT=1) and d4 (WIDTH=8, DIGIT=4).
module tb_seq_mag_comparator;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] A, B;
  logic       busy1, done1, busy4, done4;
  logic [1:0] out1, out4;

  int nchk = 0;
  int nerr = 0;

  seq_mag_comparator #(.WIDTH(8), .DIGIT(1)) d1 (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy1), .done(done1), .Out(out1)
  );

  seq_mag_comparator #(.WIDTH(8), .DIGIT(4)) d4 (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy4), .done(done4), .Out(out4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // A single-cycle start: it measures the latency from E0 to done, the number of busy cycles and the result.
  // sel=0 watches d1 and sel=1 watches d4.
  task automatic run(input string tag, input bit sel, input logic [7:0] a, input logic [7:0] b,
                     input int lat, input logic [1:0] eo);
    int  n, nbusy;
    bit  got;
    logic [1:0] o;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nbusy = (sel ? busy4 : busy1) ? 1 : 0;
    n = 0; got = 0;
    while (n < 20 && !got) begin
      @(posedge clk); #1;
      n++;
      got = sel ? done4 : done1;
      if (!got && (sel ? busy4 : busy1)) nbusy++;
    end
    o = sel ? out4 : out1;
    check({tag, " latency"}, n, lat);
    check({tag, " out"}, {30'd0, o}, {30'd0, eo});
    check({tag, " busy cycles"}, nbusy, lat);
    @(posedge clk); #1;
    check({tag, " done pulse"}, {31'd0, (sel ? done4 : done1)}, 32'd0);
    check({tag, " out held"}, {30'd0, (sel ? out4 : out1)}, {30'd0, eo});
    // Let the other instance finish so that it is idle for the next test
    repeat (12) @(posedge clk);
  endtask

  initial begin
    int seen;
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy1", {31'd0, busy1}, 32'd0);
    check("rst done1", {31'd0, done1}, 32'd0);
    check("rst out1",  {30'd0, out1}, 32'd0);
    check("rst out4",  {30'd0, out4}, 32'd0);
    @(negedge clk); rst = 1'b0;

    run("T1 eq",      0, 8'hA5, 8'hA5, 8, 2'b10);
    run("T3 lsb",     0, 8'h12, 8'h13, 8, 2'b00);
`ifdef SIGNED_CMP_EN
    run("T2 signed",  0, 8'h80, 8'h7F, 1, 2'b00);
`else
    run("T2 unsigned",0, 8'h80, 8'h7F, 1, 2'b01);
`endif
    run("T4 d4 gt",   1, 8'h3C, 8'h3A, 2, 2'b01);
    run("T4 d4 eq",   1, 8'h3C, 8'h3C, 2, 2'b10);
    check("T4 d1 out", {30'd0, out1}, {30'd0, 2'b10});

    // T5: a reset in mid-compare discards the result
    @(negedge clk);
    A = 8'hFF; B = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("T5 rst busy", {31'd0, busy1}, 32'd0);
    check("T5 rst done", {31'd0, done1}, 32'd0);
    check("T5 rst out",  {30'd0, out1}, 32'd0);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done1 || busy1) seen++;
    end
    check("T5 no publish", seen, 0);
    run("T5 after rst", 0, 8'h01, 8'h00, 8, 2'b01);

    // T6: start is held high through RUN and DONE, and the operands change after the latch
    @(negedge clk);
    A = 8'h40; B = 8'h20; start = 1'b1;
    @(posedge clk); #1;                 // E0
    A = 8'h20; B = 8'h40;
    @(posedge clk); #1;                 // E1
    check("T6 run busy", {31'd0, busy1}, 32'd1);
    @(posedge clk); #1;                 // E2
    check("T6 done1",  {31'd0, done1}, 32'd1);
    check("T6 out1",   {30'd0, out1}, {30'd0, 2'b01});
    @(posedge clk); #1;                 // E3: accepted in DONE
    start = 1'b0;
    check("T6 b2b busy", {31'd0, busy1}, 32'd1);
    check("T6 b2b done low", {31'd0, done1}, 32'd0);
    check("T6 out held", {30'd0, out1}, {30'd0, 2'b01});
    @(posedge clk); #1;                 // E4
    check("T6 mid done", {31'd0, done1}, 32'd0);
    @(posedge clk); #1;                 // E5
    check("T6 done2",  {31'd0, done1}, 32'd1);
    check("T6 out2",   {30'd0, out1}, {30'd0, 2'b00});
    repeat (12) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
